// File: rtl/uart_receiver.sv
// 8N1 UART receiver, OVERSAMPLE ticks per bit; byte lands in dout about 9.5 bit times after the start edge.
// No backpressure: rdy is sticky until rdy_clr, and a byte arriving while rdy is still set raises overrun.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       rx,
    input  logic       clken,
    input  logic       rdy_clr,
    output logic [7:0] dout,
    output logic       rdy,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sample_q, sample_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic            rxs;
    logic            good_frame;
    logic            bad_frame;

    // Synchroniser resets to the idle level so reset never looks like a start bit.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        good_frame = 1'b0;
        bad_frame  = 1'b0;
        if (clken) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d  = START;
                        sample_d = '0;
                    end
                end
                START: begin
                    if (sample_q == HALF_LAST) begin
                        sample_d = '0;
                        bit_d    = '0;
                        // A line that is high again at mid start bit was noise, not a frame.
                        state_d  = rxs ? IDLE : DATA;
                    end else begin
                        sample_d = sample_q + CW'(1);
                    end
                end
                DATA: begin
                    if (sample_q == FULL_LAST) begin
                        sample_d       = '0;
                        shift_d[bit_q] = rxs;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        sample_d = sample_q + CW'(1);
                    end
                end
                STOP: begin
                    if (sample_q == FULL_LAST) begin
                        sample_d   = '0;
                        state_d    = IDLE;
                        good_frame = rxs;
                        bad_frame  = !rxs;
                    end else begin
                        sample_d = sample_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame completion takes priority over a coinciding rdy_clr.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            dout      <= 8'h00;
            rdy       <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (good_frame) begin
            dout      <= shift_q;
            rdy       <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= rdy & ~rdy_clr;
        end else begin
            if (bad_frame) begin
                frame_err <= 1'b1;
            end
            if (rdy_clr) begin
                rdy     <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end

    assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames drive rx, expected output snapshots are queued
// per frame end, and a monitor compares them whenever rx_busy falls.
module tb_uart_receiver;

    localparam int OS  = 16;
    localparam int DIV = 27;

    logic       clk_50m = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic       clken   = 1'b0;
    logic       rdy_clr = 1'b0;
    logic [7:0] dout;
    logic       rdy;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;
    int clk_div = 0;
    logic prev_busy = 1'b0;
    logic [10:0] exp_q[$];

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .rx        (rx),
        .clken     (clken),
        .rdy_clr   (rdy_clr),
        .dout      (dout),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    always #10 clk_50m = ~clk_50m;

    function automatic logic [10:0] snap();
        return {dout, rdy, frame_err, overrun};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, input int ticks);
        rx = b;
        repeat (ticks * DIV) @(negedge clk_50m);
    endtask

    task automatic send(input logic [7:0] d, input logic stop_bit);
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        drive(stop_bit, OS);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
    endtask

    // Oversample tick: one cycle in every DIV.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (clk_div == DIV - 1) begin
                clken   = 1'b1;
                clk_div = 0;
            end else begin
                clken   = 1'b0;
                clk_div = clk_div + 1;
            end
        end
    end

    // Every return to IDLE (good frame, bad frame or rejected glitch) consumes one expectation.
    initial begin
        forever begin
            @(negedge clk_50m);
            if (!rst && prev_busy && !rx_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_end: got %h expected none queued", snap());
                end else begin
                    check("frame_end", snap(), exp_q.pop_front());
                end
            end
            prev_busy = rx_busy;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk_50m);
        check("reset_dout", 11'(dout), 11'h0);
        check("reset_rdy", 11'(rdy), 11'h0);
        check("reset_frame_err", 11'(frame_err), 11'h0);
        check("reset_overrun", 11'(overrun), 11'h0);
        check("reset_busy", 11'(rx_busy), 11'h0);
        rst = 1'b0;
        drive(1'b1, 4);

        // Single byte
        exp_q.push_back({8'hA5, 3'b100});
        send(8'hA5, 1'b1);
        drive(1'b1, OS);
        check("a5_busy_idle", 11'(rx_busy), 11'h0);
        pulse_clr();
        check("a5_after_clr", snap(), {8'hA5, 3'b000});

        // Back-to-back with acknowledge in between
        exp_q.push_back({8'h00, 3'b100});
        send(8'h00, 1'b1);
        pulse_clr();
        exp_q.push_back({8'hFF, 3'b100});
        send(8'hFF, 1'b1);
        drive(1'b1, OS);
        pulse_clr();

        // Overrun
        exp_q.push_back({8'h3C, 3'b100});
        send(8'h3C, 1'b1);
        exp_q.push_back({8'hC3, 3'b101});
        send(8'hC3, 1'b1);
        drive(1'b1, OS);
        check("overrun_before_clr", snap(), {8'hC3, 3'b101});
        pulse_clr();
        check("overrun_after_clr", snap(), {8'hC3, 3'b000});

        // Short low glitch is rejected at mid start bit
        exp_q.push_back({8'hC3, 3'b000});
        drive(1'b0, 4);
        drive(1'b1, 2 * OS);

        // Framing error; the low stop bit also re-triggers a start that is then rejected
        exp_q.push_back({8'hC3, 3'b010});
        exp_q.push_back({8'hC3, 3'b010});
        send(8'h55, 1'b0);
        drive(1'b1, 2 * OS);
        exp_q.push_back({8'h12, 3'b100});
        send(8'h12, 1'b1);
        drive(1'b1, OS);

        // Reset during data bit 4 of 0x81
        drive(1'b0, OS);
        drive(1'b1, OS);
        for (int i = 1; i < 4; i++) drive(1'b0, OS);
        drive(1'b0, OS / 2);
        #5;
        rst = 1'b1;
        rx  = 1'b1;
        #1;
        check("midrst_outputs", snap(), 11'h0);
        check("midrst_busy", 11'(rx_busy), 11'h0);
        repeat (5) @(negedge clk_50m);
        rst = 1'b0;
        drive(1'b1, OS);
        exp_q.push_back({8'h7E, 3'b100});
        send(8'h7E, 1'b1);
        drive(1'b1, OS);
        check("final_state", snap(), {8'h7E, 3'b100});

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk_50m);
        check("queue_drained", 11'(exp_q.size()), 11'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
